// File: rtl/reg_display_scanner.sv
// Register viewer front end: picks x0..x31 by key or auto-scan, reads it from a spare RF port, latches it for display.
// Build option SKIP_X0_EN: excludes x0, index range becomes 1..31.
//
// state  | meaning
// S_IDLE | waiting for a pending read request
// S_REQ  | read strobe cycle, address and index snapshot presented
// S_WAIT | extra read latency cycles (RD_LAT >= 2)
// S_CAP  | rf_rdata valid, captured into hex_val/disp_idx
module reg_display_scanner #(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int REFRESH_CYC  = 5000000,
   parameter int SCAN_CYC     = 50000000,
   parameter int RD_LAT       = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_next,
   input  logic        key_prev,
   input  logic        auto_en,
   input  logic [31:0] rf_rdata,
   output logic [4:0]  rf_raddr,
   output logic        rf_rd_en,
   output logic [31:0] hex_val,
   output logic [3:0]  idx_tens,
   output logic [3:0]  idx_ones,
   output logic        disp_en
);

`ifdef SKIP_X0_EN
   localparam logic [4:0] IDX_MIN = 5'd1;
`else
   localparam logic [4:0] IDX_MIN = 5'd0;
`endif

   localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int REF_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

   localparam logic [DB_W-1:0]   DB_LOAD   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [REF_W-1:0]  REF_LOAD  = REF_W'((REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0);
   localparam logic [SCAN_W-1:0] SCAN_LOAD = SCAN_W'(SCAN_CYC - 1);
   localparam logic [1:0]        WAIT_LOAD = 2'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CAP} state_t;

   state_t            state, state_nxt;
   logic [1:0]        key_raw, sync_a, sync_b, deb, deb_q;
   logic [DB_W-1:0]   db_cnt [2];
   logic              step_n, step_p, key_step;
   logic [SCAN_W-1:0] scan_cnt;
   logic              scan_tick;
   logic [REF_W-1:0]  ref_cnt;
   logic              ref_tick;
   logic [4:0]        idx, idx_nxt, req_idx, disp_idx;
   logic              idx_chg, pending;
   logic [1:0]        wait_cnt;
   logic              start_req, cap_now;
   logic [4:0]        ones_w;

   assign key_raw = {key_prev, key_next};

   // Released level (1) is the idle state of both synchronizer and debouncer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a    <= 2'b11;
         sync_b    <= 2'b11;
         deb       <= 2'b11;
         deb_q     <= 2'b11;
         db_cnt[0] <= DB_LOAD;
         db_cnt[1] <= DB_LOAD;
      end else begin
         sync_a <= key_raw;
         sync_b <= sync_a;
         deb_q  <= deb;
         for (int k = 0; k < 2; k++) begin
            if (sync_b[k] == deb[k]) begin
               db_cnt[k] <= DB_LOAD;
            end else if (db_cnt[k] == '0) begin
               deb[k]    <= sync_b[k];
               db_cnt[k] <= DB_LOAD;
            end else begin
               db_cnt[k] <= db_cnt[k] - DB_W'(1);
            end
         end
      end
   end

   assign step_n    = deb_q[0] & ~deb[0];
   assign step_p    = deb_q[1] & ~deb[1];
   assign key_step  = step_n | step_p;
   assign scan_tick = auto_en & (scan_cnt == '0) & ~key_step;
   assign ref_tick  = (REFRESH_CYC != 0) && (ref_cnt == '0) && !cap_now;

   always_comb begin
      idx_nxt = idx;
      idx_chg = 1'b0;
      if (step_n && !step_p) begin
         idx_nxt = (idx == 5'd31) ? IDX_MIN : idx + 5'd1;
         idx_chg = 1'b1;
      end else if (step_p && !step_n) begin
         idx_nxt = (idx == IDX_MIN) ? 5'd31 : idx - 5'd1;
         idx_chg = 1'b1;
      end else if (scan_tick) begin
         idx_nxt = (idx == 5'd31) ? IDX_MIN : idx + 5'd1;
         idx_chg = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      start_req = 1'b0;
      cap_now   = 1'b0;
      case (state)
         S_IDLE: begin
            if (pending) begin
               start_req = 1'b1;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (RD_LAT == 0) begin
               cap_now   = 1'b1;
               state_nxt = S_IDLE;
            end else if (RD_LAT == 1) begin
               state_nxt = S_CAP;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (wait_cnt == 2'd0) state_nxt = S_CAP;
         end
         S_CAP: begin
            cap_now   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         idx      <= IDX_MIN;
         req_idx  <= IDX_MIN;
         disp_idx <= IDX_MIN;
         pending  <= 1'b1;
         scan_cnt <= SCAN_LOAD;
         ref_cnt  <= REF_LOAD;
         wait_cnt <= 2'd0;
         rf_raddr <= 5'd0;
         rf_rd_en <= 1'b0;
         hex_val  <= 32'd0;
         disp_en  <= 1'b0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         rf_rd_en <= start_req;

         // A new request during an in-flight read must survive the IDLE->REQ clear.
         if (idx_chg || ref_tick) pending <= 1'b1;
         else if (start_req)      pending <= 1'b0;

         if (!auto_en || key_step || scan_cnt == '0) scan_cnt <= SCAN_LOAD;
         else                                         scan_cnt <= scan_cnt - SCAN_W'(1);

         if (REFRESH_CYC != 0) begin
            if (cap_now || ref_cnt == '0) ref_cnt <= REF_LOAD;
            else                          ref_cnt <= ref_cnt - REF_W'(1);
         end

         if (state == S_REQ)                           wait_cnt <= WAIT_LOAD;
         else if (state == S_WAIT && wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;

         if (start_req) begin
            rf_raddr <= idx;
            req_idx  <= idx;
         end

         if (cap_now) begin
            hex_val  <= rf_rdata;
            disp_idx <= req_idx;
            disp_en  <= 1'b1;
         end
      end
   end

   always_comb begin
      idx_tens = 4'd0;
      ones_w   = disp_idx;
      if (disp_idx >= 5'd30) begin
         idx_tens = 4'd3;
         ones_w   = disp_idx - 5'd30;
      end else if (disp_idx >= 5'd20) begin
         idx_tens = 4'd2;
         ones_w   = disp_idx - 5'd20;
      end else if (disp_idx >= 5'd10) begin
         idx_tens = 4'd1;
         ones_w   = disp_idx - 5'd10;
      end
      idx_ones = ones_w[3:0];
   end

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner with a 1-cycle register-file model returning 32'hA000_0000 | addr.
module tb_reg_display_scanner;
   localparam int DB = 4;
   localparam int RF = 64;
   localparam int SC = 32;
   localparam int RL = 1;
`ifdef SKIP_X0_EN
   localparam logic [4:0] IDX0 = 5'd1;
`else
   localparam logic [4:0] IDX0 = 5'd0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_next = 1'b1;
   logic        key_prev = 1'b1;
   logic        auto_en = 1'b0;
   logic [31:0] rf_rdata = 32'd0;
   logic [4:0]  rf_raddr;
   logic        rf_rd_en;
   logic [31:0] hex_val;
   logic [3:0]  idx_tens, idx_ones;
   logic        disp_en;

   int          n_vec = 0;
   int          n_err = 0;
   int          rd_cnt = 0;
   logic [4:0]  rd_q[$];
   logic [31:0] hx_q[$];
   logic [31:0] hx_last = 32'd0;
   logic [4:0]  exp_idx, e;
   int          w, c0;

   always #5 clk = ~clk;

   reg_display_scanner #(
      .DEBOUNCE_CYC(DB), .REFRESH_CYC(RF), .SCAN_CYC(SC), .RD_LAT(RL)
   ) dut (
      .clk(clk), .rst(rst), .key_next(key_next), .key_prev(key_prev), .auto_en(auto_en),
      .rf_rdata(rf_rdata), .rf_raddr(rf_raddr), .rf_rd_en(rf_rd_en), .hex_val(hex_val),
      .idx_tens(idx_tens), .idx_ones(idx_ones), .disp_en(disp_en)
   );

   // Data is only meaningful the cycle after the strobe; filler elsewhere exposes mistimed capture.
   always @(posedge clk) rf_rdata <= rf_rd_en ? (32'hA000_0000 | {27'd0, rf_raddr}) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      #1;
      if (rf_rd_en) begin
         rd_cnt++;
         rd_q.push_back(rf_raddr);
      end
      if (hex_val !== hx_last) begin
         hx_q.push_back(hex_val);
         hx_last = hex_val;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] nxt(input logic [4:0] i);
      return (i == 5'd31) ? IDX0 : i + 5'd1;
   endfunction

   function automatic logic [4:0] prv(input logic [4:0] i);
      return (i == IDX0) ? 5'd31 : i - 5'd1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // which: 0 = next, 1 = prev, 2 = both together
   task automatic press(input int which);
      if (which != 1) key_next = 1'b0;
      if (which != 0) key_prev = 1'b0;
      cyc(6);
      key_next = 1'b1;
      key_prev = 1'b1;
      cyc(10);
   endtask

   task automatic chk_disp(input string tag);
      chk({tag, "_hex"}, hex_val, 32'hA000_0000 | {27'd0, exp_idx});
      chk({tag, "_tens"}, {28'd0, idx_tens}, 32'(exp_idx / 10));
      chk({tag, "_ones"}, {28'd0, idx_ones}, 32'(exp_idx % 10));
   endtask

   task automatic wait_rd(input string tag, output int waited);
      waited = 0;
      while (!rf_rd_en && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!rf_rd_en) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no read strobe within 200 cycles", tag);
      end
   endtask

   task automatic sync_refresh();
      int ww;
      wait_rd("sync_refresh", ww);
      cyc(3);
   endtask

   initial begin
      cyc(3);
      chk("rst_rd_en", {31'd0, rf_rd_en}, 32'd0);
      chk("rst_raddr", {27'd0, rf_raddr}, 32'd0);
      chk("rst_hex", hex_val, 32'd0);
      chk("rst_disp_en", {31'd0, disp_en}, 32'd0);

      rst = 1'b1;
      wait_rd("first_rd", w);
      chk("first_rd_lat", 32'(w), 32'd1);
      chk("first_addr", {27'd0, rf_raddr}, {27'd0, IDX0});
      cyc(1);
      chk("strobe_width", {31'd0, rf_rd_en}, 32'd0);
      cyc(1);
      exp_idx = IDX0;
      chk_disp("first_read");
      chk("first_disp_en", {31'd0, disp_en}, 32'd1);

      repeat (12) begin
         press(0);
         exp_idx = nxt(exp_idx);
      end
      chk_disp("next12");

      key_next = 1'b0;
      cyc(2);
      key_next = 1'b1;
      cyc(12);
      chk_disp("glitch");

      while (exp_idx != 5'd31) begin
         press(0);
         exp_idx = nxt(exp_idx);
      end
      chk_disp("at31");
      press(0);
      exp_idx = nxt(exp_idx);
      chk_disp("wrap_next");
      press(1);
      exp_idx = prv(exp_idx);
      chk_disp("wrap_prev");

      sync_refresh();
      c0 = rd_cnt;
      press(2);
      chk("both_no_read", 32'(rd_cnt), 32'(c0));
      chk_disp("both_idx");

      while (exp_idx != 5'd5) begin
         press(0);
         exp_idx = nxt(exp_idx);
      end
      auto_en = 1'b1;
      cyc(3 * SC + 8);
      auto_en = 1'b0;
      repeat (3) exp_idx = nxt(exp_idx);
      cyc(6);
      chk_disp("auto3");

      // prev debounces two cycles behind next, so its step lands while the next-read is in flight
      sync_refresh();
      rd_q.delete();
      hx_q.delete();
      e = exp_idx;
      key_next = 1'b0;
      cyc(2);
      key_prev = 1'b0;
      cyc(4);
      key_next = 1'b1;
      cyc(2);
      key_prev = 1'b1;
      cyc(14);
      chk("inflight_reads", 32'(rd_q.size()), 32'd2);
      if (rd_q.size() >= 2) begin
         chk("inflight_addr0", {27'd0, rd_q[0]}, {27'd0, nxt(e)});
         chk("inflight_addr1", {27'd0, rd_q[1]}, {27'd0, e});
      end
      chk("inflight_hexchg", 32'(hx_q.size()), 32'd2);
      if (hx_q.size() >= 1) chk("inflight_hex0", hx_q[0], 32'hA000_0000 | {27'd0, nxt(e)});
      chk_disp("inflight_final");

      // capture restarts the refresh timer, so strobe spacing is REFRESH_CYC plus the read overhead
      wait_rd("refresh_a", w);
      cyc(1);
      wait_rd("refresh_b", w);
      chk("refresh_period", {31'd0, ((w + 1) >= RF) && ((w + 1) <= RF + 4)}, 32'd1);
      chk("refresh_addr", {27'd0, rf_raddr}, {27'd0, exp_idx});

      rst = 1'b0;
      #1;
      chk("midrd_rd_en", {31'd0, rf_rd_en}, 32'd0);
      chk("midrd_hex", hex_val, 32'd0);
      chk("midrd_disp_en", {31'd0, disp_en}, 32'd0);
      chk("midrd_raddr", {27'd0, rf_raddr}, 32'd0);
      chk("midrd_ones", {28'd0, idx_ones}, {27'd0, IDX0});
      cyc(3);
      rst = 1'b1;
      wait_rd("rerst_rd", w);
      chk("rerst_addr", {27'd0, rf_raddr}, {27'd0, IDX0});
      cyc(2);
      exp_idx = IDX0;
      chk_disp("rerst_read");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
